// File: rtl/timepulse_gen.sv
// ---------------------------------------------------------------------------
// timepulse_gen
//
// Master timing stage for the AGC gate-level simulation. It divides the
// simulation clock into timepulses T01..T12 and groups every 12 timepulses
// into one memory cycle time (MCT). It can free-run, halt at the end of
// the current MCT, or run exactly one MCT for each rising edge of step.
//
// Ports
//   clk        simulation clock; all state updates on its rising edge
//   rst        asynchronous active-high reset
//   run        level, 1 = free-run MCTs
//   stop_req   level, 1 = halt at the end of the current MCT
//   step       a rising edge requests one MCT while halted
//   tp         one-hot timepulses, bit0 = T01 .. bit11 = T12; zero when halted
//   phase      divider count within the current timepulse, 0..DIV-1
//   mct_end    high for the final clk cycle of T12
//   halted     1 when no MCT is in progress
//   mct_count  number of completed MCTs, wraps at 16 bits
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module timepulse_gen #(
  parameter int DIV = 4,   // clk cycles per timepulse, 2..16
  parameter int NTP = 12   // timepulses per MCT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           stop_req,
  input  logic           step,
  output logic [NTP-1:0] tp,
  output logic [3:0]     phase,
  output logic           mct_end,
  output logic           halted,
  output logic [15:0]    mct_count
);

  localparam logic [3:0] PH_LAST = 4'(DIV - 1);
  // mct_end is registered, so it is set one cycle ahead of the last phase.
  localparam logic [3:0] PH_PRE  = 4'(DIV - 2);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NTP-1:0]   tp_q, tp_d;
  logic [3:0]       phase_q, phase_d;
  logic             mct_end_q, mct_end_d;
  logic             halted_q, halted_d;
  logic [15:0]      mct_count_q, mct_count_d;
  logic             step_q;

  logic             step_edge;
  logic             keep_running;

  assign step_edge    = step & ~step_q;
  assign keep_running = run & ~stop_req;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      tp_q        <= '0;
      phase_q     <= '0;
      mct_end_q   <= 1'b0;
      halted_q    <= 1'b1;
      mct_count_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tp_q        <= tp_d;
      phase_q     <= phase_d;
      mct_end_q   <= mct_end_d;
      halted_q    <= halted_d;
      mct_count_q <= mct_count_d;
      step_q      <= step;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. An MCT, once started, is only left on the cycle after
  // mct_end, so run/stop_req changes never cut a cycle short.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        // run has priority; a coincident step edge is simply consumed.
        if (keep_running) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d = S_STEP1;
        end
      end
      S_RUN: begin
        if (mct_end_q && !keep_running) begin
          state_d = S_HALT;
        end
      end
      S_STEP1: begin
        if (mct_end_q) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next values of the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    tp_d        = tp_q;
    phase_d     = phase_q;
    halted_d    = halted_q;
    mct_count_d = mct_count_q;
    mct_end_d   = 1'b0;

    if (state_q == S_HALT) begin
      if (state_d != S_HALT) begin
        tp_d     = NTP'(1);
        phase_d  = '0;
        halted_d = 1'b0;
      end else begin
        tp_d     = '0;
        phase_d  = '0;
        halted_d = 1'b1;
      end
    end else if (mct_end_q) begin
      // Cycle after the last phase of T12: count it, then restart or halt.
      mct_count_d = mct_count_q + 16'd1;
      phase_d     = '0;
      if (state_d == S_RUN) begin
        tp_d     = NTP'(1);
        halted_d = 1'b0;
      end else begin
        tp_d     = '0;
        halted_d = 1'b1;
      end
    end else begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        tp_d    = {tp_q[NTP-2:0], tp_q[NTP-1]};
      end else begin
        phase_d = phase_q + 4'd1;
      end
      // Next cycle is the last phase of T12.
      mct_end_d = tp_q[NTP-1] && (phase_q == PH_PRE);
    end
  end

  assign tp        = tp_q;
  assign phase     = phase_q;
  assign mct_end   = mct_end_q;
  assign halted    = halted_q;
  assign mct_count = mct_count_q;

endmodule

// File: tb/tb_timepulse_gen.sv
// ---------------------------------------------------------------------------
// tb_timepulse_gen
//
// Self-checking bench for timepulse_gen. A reference model tracks only
// "is an MCT in progress", "is it a single-step MCT", the cycle index inside
// the MCT and the completed-MCT count; the expected tp/phase/mct_end follow
// from that index with plain arithmetic. Directed scenarios are followed by
// a randomized run/stop_req/step phase.
// ---------------------------------------------------------------------------
module tb_timepulse_gen;

  localparam int DIV     = 4;
  localparam int NTP     = 12;
  localparam int MCT_LEN = NTP * DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run = 1'b0;
  logic           stop_req = 1'b0;
  logic           step = 1'b0;
  logic [NTP-1:0] tp;
  logic [3:0]     phase;
  logic           mct_end;
  logic           halted;
  logic [15:0]    mct_count;

  timepulse_gen #(.DIV(DIV), .NTP(NTP)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .stop_req  (stop_req),
    .step      (step),
    .tp        (tp),
    .phase     (phase),
    .mct_end   (mct_end),
    .halted    (halted),
    .mct_count (mct_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_active;
  bit          m_single;
  int          m_idx;        // clk cycle index within the MCT, 0..MCT_LEN-1
  logic [15:0] m_count;
  bit          m_prev_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_single    = 1'b0;
    m_idx       = 0;
    m_count     = 16'h0000;
    m_prev_step = 1'b0;
  endtask

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_clock();
    if (!m_active) begin
      if (run && !stop_req) begin
        m_active = 1'b1;
        m_single = 1'b0;
        m_idx    = 0;
      end else if (step && !m_prev_step) begin
        m_active = 1'b1;
        m_single = 1'b1;
        m_idx    = 0;
      end
    end else if (m_idx == MCT_LEN - 1) begin
      m_count = m_count + 16'd1;
      if (!m_single && run && !stop_req) begin
        m_idx = 0;
      end else begin
        m_active = 1'b0;
        m_idx    = 0;
      end
    end else begin
      m_idx++;
    end
    m_prev_step = step;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_tp;
    logic [31:0] exp_phase;
    exp_tp    = m_active ? (32'd1 << (m_idx / DIV)) : 32'd0;
    exp_phase = m_active ? 32'(m_idx % DIV) : 32'd0;
    chk("tp",        32'(tp),        exp_tp);
    chk("phase",     32'(phase),     exp_phase);
    chk("mct_end",   32'(mct_end),   32'(m_active && (m_idx == MCT_LEN - 1)));
    chk("halted",    32'(halted),    32'(!m_active));
    chk("mct_count", 32'(mct_count), 32'(m_count));
  endtask

  // One clock: DUT and model advance on the rising edge, outputs are
  // compared on the falling edge, and the caller changes inputs afterwards.
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // ---- Reset then idle ---------------------------------------------------
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    repeat (20) tick();
    $display("idle after reset: tp=0x%03h halted=%0b count=%0d", tp, halted, mct_count);

    // ---- Free run, then drop run mid-way through the second MCT -------------
    run = 1'b1;
    for (int c = 1; c <= 2 * MCT_LEN + 1; c++) begin
      tick();
      if (c == 1)  chk("run_c1_tp",       32'(tp), 32'h001);
      if (c == 5)  chk("run_c5_tp",       32'(tp), 32'h002);
      if (c == 45) chk("run_c45_tp",      32'(tp), 32'h800);
      if (c == 48) chk("run_c48_mct_end", 32'(mct_end), 32'd1);
      if (c == 49) begin
        chk("run_c49_tp",    32'(tp),        32'h001);
        chk("run_c49_count", 32'(mct_count), 32'd1);
      end
      if (c == MCT_LEN + 10) run = 1'b0;
    end
    chk("stop_halted", 32'(halted),    32'd1);
    chk("stop_tp",     32'(tp),        32'd0);
    chk("stop_count",  32'(mct_count), 32'd2);
    $display("free run + stop: count=%0d halted=%0b", mct_count, halted);

    // ---- Single step with step held high -----------------------------------
    step = 1'b1;
    repeat (100) tick();
    chk("step_once_count",  32'(mct_count), 32'd3);
    chk("step_once_halted", 32'(halted),    32'd1);
    step = 1'b0;
    tick();
    step = 1'b1;
    repeat (MCT_LEN + 2) tick();
    chk("step_twice_count", 32'(mct_count), 32'd4);
    step = 1'b0;
    tick();
    $display("single step: count=%0d halted=%0b", mct_count, halted);

    // ---- Asynchronous reset mid-MCT ----------------------------------------
    run = 1'b1;
    repeat (20) tick();
    chk("pre_rst_tp", 32'(tp), 32'h010);
    #2 rst = 1'b1;
    #1;
    chk("arst_tp",     32'(tp),        32'd0);
    chk("arst_phase",  32'(phase),     32'd0);
    chk("arst_halted", 32'(halted),    32'd1);
    chk("arst_count",  32'(mct_count), 32'd0);
    model_reset();
    run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    $display("async reset mid-MCT: tp=0x%03h halted=%0b", tp, halted);

    // ---- Counter wrap ------------------------------------------------------
    m_count = 16'hFFFF;
    force dut.mct_count_q = 16'hFFFF;
    tick();
    release dut.mct_count_q;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (MCT_LEN) tick();
    chk("wrap_count", 32'(mct_count), 32'd0);
    $display("counter wrap: count=0x%04h", mct_count);

    // ---- Randomized run / stop_req / step ----------------------------------
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run      = ~run;
      if ($urandom_range(0, 29) == 0) stop_req = ~stop_req;
      if ($urandom_range(0, 5)  == 0) step     = ~step;
      tick();
    end
    $display("random phase done: count=%0d", mct_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
